// File: rtl/video_types.sv
// Shared video timing types: LCD mode encodings, STAT interrupt-enable bit
// positions and the default scanline geometry used by the timing controller.
package video_types;

  typedef enum logic [1:0] {
    RENDER_HBLANK = 2'd0,
    RENDER_VBLANK = 2'd1,
    RENDER_OAM    = 2'd2,
    RENDER_XFER   = 2'd3
  } render_mode_e;

  localparam int STAT_IE_HBLANK = 0;
  localparam int STAT_IE_VBLANK = 1;
  localparam int STAT_IE_OAM    = 2;
  localparam int STAT_IE_LYC    = 3;

  localparam int DEF_DOTS_PER_LINE = 456;
  localparam int DEF_VISIBLE_LINES = 144;
  localparam int DEF_TOTAL_LINES   = 154;
  localparam int DEF_OAM_DOTS      = 80;
  localparam int DEF_XFER_MIN_DOTS = 172;

  // Level of the combined STAT interrupt line for a given mode / compare state.
  function automatic logic stat_line_f(input logic [1:0] mode, input logic lyc_match,
                                       input logic [3:0] ie);
    return (ie[STAT_IE_HBLANK] && (mode == RENDER_HBLANK)) ||
           (ie[STAT_IE_VBLANK] && (mode == RENDER_VBLANK)) ||
           (ie[STAT_IE_OAM]    && (mode == RENDER_OAM))    ||
           (ie[STAT_IE_LYC]    && lyc_match);
  endfunction

endpackage

// File: rtl/lcd_timing_ctrl.sv
// LCD scan timing: dot/line counters, mode sequencing, render handshake,
// CPU access grants and VBlank/STAT interrupt generation, all registered.
module lcd_timing_ctrl
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
  parameter int OAM_DOTS      = DEF_OAM_DOTS,
  parameter int XFER_MIN_DOTS = DEF_XFER_MIN_DOTS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  input  logic       render_ack,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic       lyc_match,
  output logic       render_req,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       vram_cpu_grant,
  output logic       oam_cpu_grant,
  output logic       overrun
);

  localparam logic [8:0] DOT_LAST   = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_XFER   = 9'(OAM_DOTS);
  localparam logic [8:0] DOT_HBLANK = 9'(OAM_DOTS + XFER_MIN_DOTS);
  localparam logic [7:0] LINE_LAST  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] LINE_VBL   = 8'(VISIBLE_LINES);

  logic       running_q;
  logic       done_q;
  logic       stat_line_q;

  logic [7:0] ly_n;
  logic [8:0] dot_n;
  logic [1:0] mode_n;
  logic       req_n;
  logic       done_n;
  logic       run_n;
  logic       ovr_n;
  logic       vbl_n;
  logic       lyc_n;
  logic       stat_line_n;
  logic       visible_n;
  logic       line_wrap;
  logic       ack_take;

  assign line_wrap = (dot == DOT_LAST);
  assign ack_take  = render_req & render_ack;

  // Next-state: every registered output is derived from the same (ly_n, dot_n).
  always_comb begin
    ly_n      = ly;
    dot_n     = dot;
    mode_n    = mode;
    req_n     = render_req;
    done_n    = done_q;
    run_n     = running_q;
    ovr_n     = overrun;
    visible_n = 1'b0;
    if (!lcd_enable) begin
      ly_n   = '0;
      dot_n  = '0;
      mode_n = RENDER_HBLANK;
      req_n  = 1'b0;
      done_n = 1'b0;
      run_n  = 1'b0;
    end else if (!running_q) begin
      ly_n   = '0;
      dot_n  = '0;
      mode_n = RENDER_OAM;
      req_n  = 1'b0;
      done_n = 1'b0;
      run_n  = 1'b1;
    end else begin
      if (line_wrap) begin
        dot_n  = '0;
        ly_n   = (ly == LINE_LAST) ? 8'd0 : ly + 8'd1;
        done_n = 1'b0;
        req_n  = 1'b0;
        ovr_n  = overrun | render_req;
      end else begin
        dot_n  = dot + 9'd1;
        done_n = done_q | ack_take;
        if (ack_take) req_n = 1'b0;
      end
      visible_n = (ly_n < LINE_VBL);
      if (!visible_n)                          mode_n = RENDER_VBLANK;
      else if (dot_n < DOT_XFER)               mode_n = RENDER_OAM;
      else if (done_n && (dot_n >= DOT_HBLANK)) mode_n = RENDER_HBLANK;
      else                                     mode_n = RENDER_XFER;
      if (visible_n && (dot_n == DOT_XFER)) req_n = 1'b1;
    end
    vbl_n       = lcd_enable && running_q && (ly_n == LINE_VBL) && (dot_n == 9'd0);
    lyc_n       = (ly_n == lyc);
    stat_line_n = stat_line_f(mode_n, lyc_n, stat_ie);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ly             <= '0;
      dot            <= '0;
      mode           <= RENDER_HBLANK;
      render_req     <= 1'b0;
      vblank_irq     <= 1'b0;
      stat_irq       <= 1'b0;
      overrun        <= 1'b0;
      vram_cpu_grant <= 1'b1;
      oam_cpu_grant  <= 1'b1;
      lyc_match      <= (lyc == 8'd0);
      stat_line_q    <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      ly             <= ly_n;
      dot            <= dot_n;
      mode           <= mode_n;
      render_req     <= req_n;
      vblank_irq     <= vbl_n;
      stat_irq       <= stat_line_n & ~stat_line_q;
      overrun        <= ovr_n;
      vram_cpu_grant <= (mode_n != RENDER_XFER);
      oam_cpu_grant  <= (mode_n == RENDER_HBLANK) || (mode_n == RENDER_VBLANK);
      lyc_match      <= lyc_n;
      stat_line_q    <= stat_line_n;
      running_q      <= run_n;
      done_q         <= done_n;
    end
  end

endmodule
